clo_clz_sched: RTL

Shared count-leading-ones/zeros scheduler for the execute stage. It arbitrates two requesters, e.g. two issue pipes executing CLO/CLZ, onto a single 8-bit leading-bit counter. It scans the 32-bit operand one byte per cycle, most-significant byte first, and stops at the first byte that is not all-matching. The result returns on one response channel with a valid/ready handshake, plus a flush for exception/branch kill.

---
 rtl/clo_clz_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/clo_clz_sched.sv
// Shared CLO/CLZ engine: round-robin arbitration of two requesters onto one
// byte-wide leading-bit counter that scans the operand MSB byte first.
module clo_clz_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_op,
    input  logic [31:0] req0_val,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_op,
    input  logic [31:0] req1_val,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_val;
    logic        r_op;
    logic        r_id;
    logic        r_last_grant;
    logic [1:0]  r_byte_idx;
    logic [5:0]  r_acc;
    logic        r_rsp_valid;
    logic        r_busy;

    logic        w_grant;
    logic        w_idle_ok;
    logic        w_accept;
    logic        w_acc_sel_op;
    logic [31:0] w_acc_sel_val;
    logic [7:0]  w_byte;
    logic [7:0]  w_match;
    logic [3:0]  w_cnt;
    logic        w_last_byte;

    // Grant: the lone valid requester, or the one that did not win last time.
    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req1_valid;
        end
    end

    assign w_idle_ok  = (r_state == ST_IDLE) && !flush;
    assign req0_ready = w_idle_ok && req0_valid && !w_grant;
    assign req1_ready = w_idle_ok && req1_valid && w_grant;
    assign w_accept   = req0_ready || req1_ready;

    assign w_acc_sel_op  = w_grant ? req1_op  : req0_op;
    assign w_acc_sel_val = w_grant ? req1_val : req0_val;

    // Shared byte counter.
    assign w_byte = r_val[{r_byte_idx, 3'b000} +: 8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_match
            assign w_match[gi] = (w_byte[gi] == r_op);
        end
    endgenerate

    // Highest non-matching bit wins because it is assigned last.
    always_comb begin
        w_cnt = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (!w_match[i]) begin
                w_cnt = 4'(7 - i);
            end
        end
    end

    assign w_last_byte = (w_cnt != 4'd8) || (r_byte_idx == 2'd0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_next = ST_SCAN;
            ST_SCAN: if (w_last_byte) w_state_next = ST_DONE;
            ST_DONE: if (rsp_ready)   w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
        if (flush) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rsp_valid <= (w_state_next == ST_DONE);
            r_busy      <= (w_state_next != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val        <= 32'd0;
            r_op         <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_byte_idx   <= 2'd3;
            r_acc        <= 6'd0;
        end else if (w_accept) begin
            r_val        <= w_acc_sel_val;
            r_op         <= w_acc_sel_op;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_byte_idx   <= 2'd3;
            r_acc        <= 6'd0;
        end else if (r_state == ST_SCAN && !flush) begin
            // A full byte contributes 8, so one adder covers both outcomes.
            r_acc <= r_acc + {2'b00, w_cnt};
            if (!w_last_byte) begin
                r_byte_idx <= r_byte_idx - 2'd1;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_count = {26'd0, r_acc};
    assign busy      = r_busy;

endmodule
